// File: rtl/time_of_day_counter.sv
`default_nettype none
// ============================================================================
//  Module   : time_of_day_counter
//  Purpose  : HH:MM BCD time-of-day counter with RUN / SET_HR / SET_MIN modes.
//             Optional macro FORMAT_12H_EN selects 12-hour display with PM flag.
//  Revision : 1.0  initial release
// ============================================================================
module time_of_day_counter #(
    parameter int SEC_PER_MIN = 60
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_1hz_i,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    output logic [3:0] digit1_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit3_o,
    output logic [3:0] digit4_o,
    output logic [1:0] mode_o,
    output logic       colon_o,
    output logic       pm_o,
    output logic       day_wrap_o
);

    localparam int                C_SEC_W    = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [C_SEC_W-1:0] C_SEC_LAST = C_SEC_W'(SEC_PER_MIN - 1);
    localparam logic [7:0]        C_HR_MAX   = 8'h23;
    localparam logic [7:0]        C_MIN_MAX  = 8'h59;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    // Hours and minutes are held as two packed BCD nibbles {tens, units}
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == vmax)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == 8'h00)
            r = vmax;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    mode_e              mode_q, mode_d;
    logic [C_SEC_W-1:0] sec_q, sec_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         hr_q, hr_d;
    logic               colon_q, colon_d;
    logic               day_wrap_q, day_wrap_d;

    logic w_edit_up;
    logic w_edit_dn;

    assign w_edit_up = btn_up_i & ~btn_down_i;
    assign w_edit_dn = btn_down_i & ~btn_up_i;

    always_comb begin
        mode_d     = mode_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        colon_d    = colon_q;
        day_wrap_d = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                if (tick_1hz_i) begin
                    colon_d = ~colon_q;
                    if (sec_q == C_SEC_LAST) begin
                        sec_d = '0;
                        min_d = bcd_inc(min_q, C_MIN_MAX);
                        if (min_q == C_MIN_MAX) begin
                            hr_d = bcd_inc(hr_q, C_HR_MAX);
                            if (hr_q == C_HR_MAX)
                                day_wrap_d = 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + C_SEC_W'(1);
                    end
                end
                if (btn_mode_i)
                    mode_d = MODE_SET_HR;
            end
            MODE_SET_HR: begin
                if (btn_mode_i)
                    mode_d = MODE_SET_MIN;
                else if (w_edit_up)
                    hr_d = bcd_inc(hr_q, C_HR_MAX);
                else if (w_edit_dn)
                    hr_d = bcd_dec(hr_q, C_HR_MAX);
            end
            MODE_SET_MIN: begin
                if (btn_mode_i) begin
                    mode_d = MODE_RUN;
                    sec_d  = '0;
                end else if (w_edit_up) begin
                    min_d = bcd_inc(min_q, C_MIN_MAX);
                end else if (w_edit_dn) begin
                    min_d = bcd_dec(min_q, C_MIN_MAX);
                end
            end
            default: mode_d = MODE_RUN;
        endcase

        // Colon is steady whenever the clock is paused for editing
        if (mode_d != MODE_RUN)
            colon_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= MODE_RUN;
            sec_q      <= '0;
            min_q      <= 8'h00;
            hr_q       <= 8'h00;
            colon_q    <= 1'b1;
            day_wrap_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            colon_q    <= colon_d;
            day_wrap_q <= day_wrap_d;
        end
    end

`ifdef FORMAT_12H_EN
    // Map the internal 00..23 BCD hour to a 01..12 display value plus PM flag
    function automatic logic [8:0] map_12h(input logic [7:0] h);
        logic [7:0] disp;
        logic       pm;
        pm = (h >= 8'h12);
        if (h == 8'h00)
            disp = 8'h12;
        else if (h <= 8'h12)
            disp = h;
        else if (h <= 8'h19)
            disp = {4'd0, h[3:0] - 4'd2};
        else if (h <= 8'h21)
            disp = {4'd0, h[3:0] + 4'd8};
        else
            disp = {4'd1, h[3:0] - 4'd2};
        return {pm, disp};
    endfunction

    logic [7:0] disp_hr_q;
    logic       pm_q;
    logic [8:0] w_map_d;

    assign w_map_d = map_12h(hr_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_hr_q <= 8'h12;
            pm_q      <= 1'b0;
        end else begin
            disp_hr_q <= w_map_d[7:0];
            pm_q      <= w_map_d[8];
        end
    end

    assign digit1_o = disp_hr_q[7:4];
    assign digit2_o = disp_hr_q[3:0];
    assign pm_o     = pm_q;
`else
    assign digit1_o = hr_q[7:4];
    assign digit2_o = hr_q[3:0];
    assign pm_o     = 1'b0;
`endif

    assign digit3_o   = min_q[7:4];
    assign digit4_o   = min_q[3:0];
    assign mode_o     = mode_q;
    assign colon_o    = colon_q;
    assign day_wrap_o = day_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_time_of_day_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_of_day_counter
//  Purpose  : Randomised scoreboard bench for time_of_day_counter (SEC_PER_MIN=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_of_day_counter;

    localparam int SPM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, bmode, bup, bdown;
    logic [3:0] d1, d2, d3, d4;
    logic [1:0] mode;
    logic       colon, pm, day_wrap;

    always #5 clk = ~clk;

    time_of_day_counter #(.SEC_PER_MIN(SPM)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_1hz_i (tick),
        .btn_mode_i (bmode),
        .btn_up_i   (bup),
        .btn_down_i (bdown),
        .digit1_o   (d1),
        .digit2_o   (d2),
        .digit3_o   (d3),
        .digit4_o   (d4),
        .mode_o     (mode),
        .colon_o    (colon),
        .pm_o       (pm),
        .day_wrap_o (day_wrap)
    );

    typedef struct packed {
        logic [3:0] d1, d2, d3, d4;
        logic [1:0] mode;
        logic       colon, pm, dw;
    } obs_t;

    obs_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: plain integers for hours/minutes/seconds
    int m_hr, m_min, m_sec, m_mode;
    bit m_colon, m_dw;

    function automatic obs_t model_out();
        obs_t e;
        int   h;
        bit   p;
`ifdef FORMAT_12H_EN
        h = (m_hr % 12 == 0) ? 12 : m_hr % 12;
        p = (m_hr >= 12);
`else
        h = m_hr;
        p = 1'b0;
`endif
        e.d1    = 4'(h / 10);
        e.d2    = 4'(h % 10);
        e.d3    = 4'(m_min / 10);
        e.d4    = 4'(m_min % 10);
        e.mode  = 2'(m_mode);
        e.colon = m_colon;
        e.pm    = p;
        e.dw    = m_dw;
        return e;
    endfunction

    task automatic model_reset();
        m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0; m_colon = 1'b1; m_dw = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit m, input bit u, input bit d);
        m_dw = 1'b0;
        case (m_mode)
            0: begin
                if (t) begin
                    m_colon = !m_colon;
                    m_sec   = m_sec + 1;
                    if (m_sec == SPM) begin
                        m_sec = 0;
                        m_min = m_min + 1;
                        if (m_min == 60) begin
                            m_min = 0;
                            m_hr  = m_hr + 1;
                            if (m_hr == 24) begin
                                m_hr = 0;
                                m_dw = 1'b1;
                            end
                        end
                    end
                end
                if (m) m_mode = 1;
            end
            1: begin
                if (m)           m_mode = 2;
                else if (u && !d) m_hr = (m_hr + 1) % 24;
                else if (d && !u) m_hr = (m_hr + 23) % 24;
            end
            default: begin
                if (m) begin
                    m_mode = 0;
                    m_sec  = 0;
                end else if (u && !d) m_min = (m_min + 1) % 60;
                else if (d && !u)     m_min = (m_min + 59) % 60;
            end
        endcase
        if (m_mode != 0) m_colon = 1'b1;
    endtask

    task automatic cyc(input bit t, input bit m, input bit u, input bit d);
        @(negedge clk);
        rst_n = 1'b1; tick = t; bmode = m; bup = u; bdown = d;
        model_step(t, m, u, d);
        sb_q.push_back(model_out());
    endtask

    // Reset asserted at the falling edge, i.e. mid-cycle and asynchronously
    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0; tick = 0; bmode = 0; bup = 0; bdown = 0;
        model_reset();
        sb_q.push_back(model_out());
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = '{d1: d1, d2: d2, d3: d3, d4: d4, mode: mode,
                      colon: colon, pm: pm, dw: day_wrap};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t: got %h%h:%h%h mode=%0d colon=%b pm=%b dw=%b, want %h%h:%h%h mode=%0d colon=%b pm=%b dw=%b",
                             n_vec, $time, a.d1, a.d2, a.d3, a.d4, a.mode, a.colon, a.pm, a.dw,
                             e.d1, e.d2, e.d3, e.d4, e.mode, e.colon, e.pm, e.dw);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; tick = 0; bmode = 0; bup = 0; bdown = 0;
        model_reset();
        rst_pulse();
        rst_pulse();

        // One minute of ticks, then idle
        repeat (SPM) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // SET_HR wraps and paused ticks
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0);

        // SET_MIN wraps, simultaneous up+down, then preload 23:59
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);

        // Day rollover
        repeat (SPM) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);

        // Mode beats edit, then reset mid-edit
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        rst_pulse();
        cyc(0, 0, 0, 0);

        // Tick coinciding with mode in RUN
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);

        // Walk every hour value in SET_HR for display mapping
        repeat (25) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_pulse();
            end else begin
                cyc($urandom_range(0, 2) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0);
            end
        end
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never observed, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
